// File: rtl/tblink_rpc_pkg.sv
// tblink_rpc_pkg -- shared FSM encodings, frame offsets and helpers for the TBLink RPC message processor (rev 1.0)
`default_nettype none

package tblink_rpc_pkg;

    localparam logic [7:0] CMD_RSP = 8'h00;

    localparam int FRM_OFS_DST  = 0;
    localparam int FRM_OFS_SZ   = 1;
    localparam int FRM_OFS_CMD  = 2;
    localparam int FRM_OFS_ID   = 3;
    localparam int FRM_OFS_DATA = 4;

    // Inbound frames carry no DST byte, so each RX state sits one offset lower.
    typedef enum logic [2:0] {
        RX_SZ        = 3'(FRM_OFS_SZ - 1),
        RX_CMD       = 3'(FRM_OFS_CMD - 1),
        RX_ID        = 3'(FRM_OFS_ID - 1),
        RX_DATA      = 3'(FRM_OFS_DATA - 1),
        REQ_EXEC     = 3'd4,
        REQ_RSP_WAIT = 3'd5
    } tipo_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_DST  = 3'(FRM_OFS_DST + 1),
        TX_SZ   = 3'(FRM_OFS_SZ + 1),
        TX_CMD  = 3'(FRM_OFS_CMD + 1),
        TX_ID   = 3'(FRM_OFS_ID + 1),
        TX_DATA = 3'(FRM_OFS_DATA + 1)
    } tipi_state_t;

    function automatic logic [7:0] clamp_sz(input logic [7:0] n, input int cap);
        if (int'(n) > cap) return 8'(cap);
        return n;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tblink_rpc_frame_tx.sv
// tblink_rpc_frame_tx -- TIPI frame serialiser: arbitrates response vs. request and emits DST/SZ/CMD/ID/payload (rev 1.0)
`default_nettype none

module tblink_rpc_frame_tx
    import tblink_rpc_pkg::*;
#(
    parameter int         RSP_SZ = 4,
    parameter int         REQ_SZ = 4,
    parameter logic [7:0] DST_ID = 8'h00
) (
    input  logic                  uclock,
    input  logic                  reset,
    input  logic                  rsp_valid_i,
    input  logic [7:0]            rsp_sz_i,
    input  logic [7:0]            rsp_id_i,
    input  logic [8*RSP_SZ-1:0]   rsp_dat_i,
    output logic                  rsp_done_o,
    input  logic                  req_valid_i,
    input  logic [7:0]            req_cmd_i,
    input  logic [7:0]            req_sz_i,
    input  logic [7:0]            req_id_i,
    input  logic [8*REQ_SZ-1:0]   req_dat_i,
    output logic                  req_issue_o,
    output logic                  req_sent_o,
    output logic                  tipi_valid_o,
    input  logic                  tipi_ready_i,
    output logic [7:0]            tipi_dat_o
);

    localparam int BUF_W = 8 * max_int(RSP_SZ, REQ_SZ);

    tipi_state_t      state_q;
    logic             is_rsp_q;
    logic [7:0]       sz_q;
    logic [7:0]       cmd_q;
    logic [7:0]       id_q;
    logic [BUF_W-1:0] dat_q;

    logic w_fire;
    logic w_last;
    logic [7:0] w_dat;

    assign tipi_valid_o = (state_q != IDLE);
    assign w_fire       = tipi_valid_o & tipi_ready_i;
    assign w_last       = w_fire & (((state_q == TX_ID) & (sz_q == 8'd0)) |
                                    ((state_q == TX_DATA) & (sz_q == 8'd1)));
    assign rsp_done_o   = w_last & is_rsp_q;
    assign req_sent_o   = w_last & ~is_rsp_q;
    // A pending response to an inbound request always wins the idle slot.
    assign req_issue_o  = (state_q == IDLE) & ~rsp_valid_i & req_valid_i;
    assign tipi_dat_o   = w_dat;

    always_comb begin
        w_dat = 8'h00;
        case (state_q)
            TX_DST:  w_dat = DST_ID;
            TX_SZ:   w_dat = sz_q + 8'd1;
            TX_CMD:  w_dat = cmd_q;
            TX_ID:   w_dat = id_q;
            TX_DATA: w_dat = dat_q[7:0];
            default: w_dat = 8'h00;
        endcase
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            is_rsp_q <= 1'b0;
            sz_q     <= 8'd0;
            cmd_q    <= 8'd0;
            id_q     <= 8'd0;
            dat_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rsp_valid_i) begin
                        is_rsp_q <= 1'b1;
                        sz_q     <= rsp_sz_i;
                        cmd_q    <= CMD_RSP;
                        id_q     <= rsp_id_i;
                        dat_q    <= BUF_W'(rsp_dat_i);
                        state_q  <= TX_DST;
                    end else if (req_valid_i) begin
                        is_rsp_q <= 1'b0;
                        sz_q     <= clamp_sz(req_sz_i, REQ_SZ);
                        cmd_q    <= req_cmd_i;
                        id_q     <= req_id_i;
                        dat_q    <= BUF_W'(req_dat_i);
                        state_q  <= TX_DST;
                    end
                end
                TX_DST:  if (w_fire) state_q <= TX_SZ;
                TX_SZ:   if (w_fire) state_q <= TX_CMD;
                TX_CMD:  if (w_fire) state_q <= TX_ID;
                TX_ID:   if (w_fire) state_q <= (sz_q == 8'd0) ? IDLE : TX_DATA;
                TX_DATA: begin
                    if (w_fire) begin
                        dat_q <= dat_q >> 8;
                        sz_q  <= sz_q - 8'd1;
                        if (sz_q == 8'd1) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tblink_rpc_msgproc.sv
// tblink_rpc_msgproc -- TBLink RPC message processor: TIPO frame parser plus TIPI serialiser (rev 1.0)
// Build option: define TBLINK_RPC_MSGPROC_IDCHK_EN to reject responses whose ID mismatches the outstanding request.
`default_nettype none

module tblink_rpc_msgproc
    import tblink_rpc_pkg::*;
#(
    parameter int         CMD_IN_PARAMS_SZ  = 4,
    parameter int         CMD_IN_RSP_SZ     = 4,
    parameter int         CMD_OUT_PARAMS_SZ = 4,
    parameter int         CMD_OUT_RSP_SZ    = 4,
    parameter logic [7:0] DST_ID            = 8'h00
) (
    input  logic                            uclock,
    input  logic                            reset,
    input  logic                            tipo_valid,
    output logic                            tipo_ready,
    input  logic [7:0]                      tipo_dat,
    output logic                            tipi_valid,
    input  logic                            tipi_ready,
    output logic [7:0]                      tipi_dat,
    output logic [7:0]                      cmd_in,
    output logic [7:0]                      cmd_in_sz,
    output logic [7:0]                      cmd_in_id,
    output logic [8*CMD_IN_PARAMS_SZ-1:0]   cmd_in_params,
    output logic                            cmd_in_put_i,
    input  logic                            cmd_in_get_i,
    input  logic [8*CMD_IN_RSP_SZ-1:0]      cmd_in_rsp,
    input  logic [7:0]                      cmd_in_rsp_sz,
    input  logic [7:0]                      cmd_out,
    input  logic [7:0]                      cmd_out_sz,
    input  logic [8*CMD_OUT_PARAMS_SZ-1:0]  cmd_out_params,
    input  logic                            cmd_out_put_i,
    output logic                            cmd_out_get_i,
    output logic [8*CMD_OUT_RSP_SZ-1:0]     cmd_out_rsp,
    output logic [7:0]                      cmd_out_rsp_sz,
    output logic                            err
);

    localparam int RX_BUF_SZ = max_int(CMD_IN_PARAMS_SZ, CMD_OUT_RSP_SZ);

    tipo_state_t                     tipo_q;
    logic [7:0]                      plen_q;
    logic [7:0]                      cnt_q;
    logic [7:0]                      rx_cmd_q;
    logic [7:0]                      rx_id_q;
    logic [8*RX_BUF_SZ-1:0]          rx_buf_q;
    logic [8*RX_BUF_SZ-1:0]          rx_buf_d;
    logic [7:0]                      cmd_in_q;
    logic [7:0]                      cmd_in_sz_q;
    logic [7:0]                      cmd_in_id_q;
    logic [8*CMD_IN_PARAMS_SZ-1:0]   cmd_in_params_q;
    logic                            put_q;
    logic [7:0]                      rsp_sz_q;
    logic [8*CMD_IN_RSP_SZ-1:0]      rsp_dat_q;
    logic                            out_get_q;
    logic [8*CMD_OUT_RSP_SZ-1:0]     out_rsp_q;
    logic [7:0]                      out_rsp_sz_q;
    logic                            busy_q;
    logic [7:0]                      tx_id_q;
    logic                            err_q;
`ifdef TBLINK_RPC_MSGPROC_IDCHK_EN
    logic [7:0]                      out_id_q;
`endif

    logic       w_rx_fire;
    logic       w_last;
    logic       w_is_rsp;
    logic [7:0] w_id;
    logic       w_id_ok;
    logic       w_rsp_take;
    logic       w_rsp_drop;
    logic       w_req_pend;
    logic       w_req_issue;
    logic       w_req_sent;
    logic       w_rsp_done;

    assign tipo_ready = (tipo_q == RX_SZ) | (tipo_q == RX_CMD) |
                        (tipo_q == RX_ID) | (tipo_q == RX_DATA);
    assign w_rx_fire  = tipo_valid & tipo_ready;
    assign w_id       = (tipo_q == RX_ID) ? tipo_dat : rx_id_q;
    assign w_is_rsp   = (rx_cmd_q == CMD_RSP);
    assign w_last     = w_rx_fire & (((tipo_q == RX_ID) & (plen_q == 8'd0)) |
                                     ((tipo_q == RX_DATA) & (cnt_q == plen_q - 8'd1)));
`ifdef TBLINK_RPC_MSGPROC_IDCHK_EN
    assign w_id_ok    = (w_id == out_id_q);
`else
    assign w_id_ok    = 1'b1;
`endif
    assign w_rsp_take = w_last & w_is_rsp & busy_q & w_id_ok;
    assign w_rsp_drop = w_last & w_is_rsp & ~w_rsp_take;
    assign w_req_pend = (cmd_out_put_i != out_get_q) & ~busy_q;

    // Merge the byte being accepted so a frame's final byte is visible at completion.
    always_comb begin
        rx_buf_d = rx_buf_q;
        if (w_rx_fire && tipo_q == RX_DATA) begin
            for (int b = 0; b < RX_BUF_SZ; b++) begin
                if (cnt_q == 8'(b)) rx_buf_d[8*b +: 8] = tipo_dat;
            end
        end
    end

    tblink_rpc_frame_tx #(
        .RSP_SZ (CMD_IN_RSP_SZ),
        .REQ_SZ (CMD_OUT_PARAMS_SZ),
        .DST_ID (DST_ID)
    ) u_frame_tx (
        .uclock       (uclock),
        .reset        (reset),
        .rsp_valid_i  (tipo_q == REQ_RSP_WAIT),
        .rsp_sz_i     (rsp_sz_q),
        .rsp_id_i     (cmd_in_id_q),
        .rsp_dat_i    (rsp_dat_q),
        .rsp_done_o   (w_rsp_done),
        .req_valid_i  (w_req_pend),
        .req_cmd_i    (cmd_out),
        .req_sz_i     (cmd_out_sz),
        .req_id_i     (tx_id_q),
        .req_dat_i    (cmd_out_params),
        .req_issue_o  (w_req_issue),
        .req_sent_o   (w_req_sent),
        .tipi_valid_o (tipi_valid),
        .tipi_ready_i (tipi_ready),
        .tipi_dat_o   (tipi_dat)
    );

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            tipo_q          <= RX_SZ;
            plen_q          <= 8'd0;
            cnt_q           <= 8'd0;
            rx_cmd_q        <= 8'd0;
            rx_id_q         <= 8'd0;
            rx_buf_q        <= '0;
            cmd_in_q        <= 8'd0;
            cmd_in_sz_q     <= 8'd0;
            cmd_in_id_q     <= 8'd0;
            cmd_in_params_q <= '0;
            put_q           <= 1'b0;
            rsp_sz_q        <= 8'd0;
            rsp_dat_q       <= '0;
            out_get_q       <= 1'b0;
            out_rsp_q       <= '0;
            out_rsp_sz_q    <= 8'd0;
            busy_q          <= 1'b0;
            tx_id_q         <= 8'd0;
            err_q           <= 1'b0;
`ifdef TBLINK_RPC_MSGPROC_IDCHK_EN
            out_id_q        <= 8'd0;
`endif
        end else begin
            err_q  <= w_rsp_drop;
            busy_q <= (busy_q & ~w_rsp_take) | w_req_issue;
            if (w_req_sent) tx_id_q <= tx_id_q + 8'd1;
`ifdef TBLINK_RPC_MSGPROC_IDCHK_EN
            if (w_req_issue) out_id_q <= tx_id_q;
`endif
            case (tipo_q)
                RX_SZ: begin
                    if (w_rx_fire) begin
                        plen_q   <= (tipo_dat == 8'd0) ? 8'd0 : tipo_dat - 8'd1;
                        cnt_q    <= 8'd0;
                        rx_buf_q <= '0;
                        tipo_q   <= RX_CMD;
                    end
                end
                RX_CMD: begin
                    if (w_rx_fire) begin
                        rx_cmd_q <= tipo_dat;
                        tipo_q   <= RX_ID;
                    end
                end
                RX_ID, RX_DATA: begin
                    if (w_rx_fire) begin
                        rx_id_q  <= w_id;
                        rx_buf_q <= rx_buf_d;
                        if (tipo_q == RX_DATA) cnt_q <= cnt_q + 8'd1;
                        if (!w_last) begin
                            tipo_q <= RX_DATA;
                        end else if (!w_is_rsp) begin
                            cmd_in_q        <= rx_cmd_q;
                            cmd_in_id_q     <= w_id;
                            cmd_in_sz_q     <= clamp_sz(plen_q, CMD_IN_PARAMS_SZ);
                            cmd_in_params_q <= rx_buf_d[8*CMD_IN_PARAMS_SZ-1:0];
                            put_q           <= ~put_q;
                            tipo_q          <= REQ_EXEC;
                        end else begin
                            if (w_rsp_take) begin
                                out_rsp_q    <= rx_buf_d[8*CMD_OUT_RSP_SZ-1:0];
                                out_rsp_sz_q <= clamp_sz(plen_q, CMD_OUT_RSP_SZ);
                                out_get_q    <= ~out_get_q;
                            end
                            tipo_q <= RX_SZ;
                        end
                    end
                end
                REQ_EXEC: begin
                    if (cmd_in_get_i == put_q) begin
                        rsp_sz_q  <= clamp_sz(cmd_in_rsp_sz, CMD_IN_RSP_SZ);
                        rsp_dat_q <= cmd_in_rsp;
                        tipo_q    <= REQ_RSP_WAIT;
                    end
                end
                REQ_RSP_WAIT: begin
                    if (w_rsp_done) tipo_q <= RX_SZ;
                end
                default: tipo_q <= RX_SZ;
            endcase
        end
    end

    assign cmd_in         = cmd_in_q;
    assign cmd_in_sz      = cmd_in_sz_q;
    assign cmd_in_id      = cmd_in_id_q;
    assign cmd_in_params  = cmd_in_params_q;
    assign cmd_in_put_i   = put_q;
    assign cmd_out_get_i  = out_get_q;
    assign cmd_out_rsp    = out_rsp_q;
    assign cmd_out_rsp_sz = out_rsp_sz_q;
    assign err            = err_q;

endmodule

`default_nettype wire

// File: doc/tblink_rpc_msgproc.md
TBLINK_RPC_MSGPROC -- requirements
Module: tblink_rpc_msgproc

Interface
REQ-001 SHALL have parameter CMD_IN_PARAMS_SZ, default 4, meaning byte capacity of inbound request payload.
REQ-002 SHALL have parameter CMD_IN_RSP_SZ, default 4, meaning byte capacity of response payload to inbound requests.
REQ-003 SHALL have parameter CMD_OUT_PARAMS_SZ, default 4, meaning byte capacity of outbound request payload.
REQ-004 SHALL have parameter CMD_OUT_RSP_SZ, default 4, meaning byte capacity of response payload to outbound requests.
REQ-005 SHALL have parameter DST_ID, default 0, meaning the 8-bit destination byte prefixed to every TIPI frame.
REQ-006 SHALL have ports, in order:
- uclock  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- tipo_valid/tipo_ready/tipo_dat  in/out/in  1/1/8  inbound byte stream (target)
- tipi_valid/tipi_ready/tipi_dat  out/in/out  1/1/8  outbound byte stream (initiator)
- cmd_in, cmd_in_sz, cmd_in_id  out  8 each  received request command, payload byte count, ID
- cmd_in_params  out  8*CMD_IN_PARAMS_SZ  received request payload
- cmd_in_put_i  out  1  toggles when an inbound request is ready
- cmd_in_get_i  in  1  client toggles to match put: request consumed, response valid
- cmd_in_rsp, cmd_in_rsp_sz  in  8*CMD_IN_RSP_SZ, 8  response payload and byte count
- cmd_out, cmd_out_sz  in  8 each  outbound command, payload byte count
- cmd_out_params  in  8*CMD_OUT_PARAMS_SZ  outbound payload
- cmd_out_put_i  in  1  client toggles to issue a request
- cmd_out_get_i  out  1  toggles when the response to the outstanding request has arrived
- cmd_out_rsp, cmd_out_rsp_sz  out  8*CMD_OUT_RSP_SZ, 8  returned response payload and byte count
- err  out  1  single-cycle protocol-error pulse

Function
REQ-007 Frame after DST: SZ, CMD, ID, then SZ-1 payload bytes; CMD==0 is a response, nonzero a request; SZ==0 SHALL be treated as SZ==1.
REQ-008 Payload byte k SHALL map to bits [8k+:8] in both directions; inbound bytes with k >= capacity SHALL be consumed and discarded; outbound byte counts SHALL be clamped to capacity.
REQ-009 TIPO FSM states: RX_SZ, RX_CMD, RX_ID, RX_DATA, REQ_EXEC, REQ_RSP_WAIT; tipo_ready SHALL be 1 only in RX_SZ/RX_CMD/RX_ID/RX_DATA.
REQ-010 Inbound request: after the last byte, load cmd_in*, toggle cmd_in_put_i, enter REQ_EXEC; cmd_in_params bytes beyond cmd_in_sz SHALL be 0.
REQ-011 In REQ_EXEC, when cmd_in_get_i==cmd_in_put_i, capture cmd_in_rsp/sz and request a TIPI response; return to RX_SZ when TIPI finishes sending it (REQ_RSP_WAIT).
REQ-012 Inbound response: after the last byte, load cmd_out_rsp/cmd_out_rsp_sz, toggle cmd_out_get_i, clear out-busy, return to RX_SZ; with no request outstanding, discard it and pulse err.
REQ-013 TIPI FSM states: IDLE, TX_DST, TX_SZ, TX_CMD, TX_ID, TX_DATA; tipi_valid SHALL be 1 in all TX_* states; a byte advances only on tipi_valid&&tipi_ready.
REQ-014 In IDLE, a pending inbound-request response SHALL have priority over a new outbound request; a new outbound request (cmd_out_put_i != cmd_out_get_i, not out-busy) SHALL latch cmd_out* and set out-busy.
REQ-015 Response frame: DST_ID, rsp_sz+1, 0, captured cmd_in_id, rsp_sz bytes; request frame: DST_ID, sz+1, cmd_out, tx_id, sz bytes; tx_id SHALL increment by 1 (mod 256) after each request sent.
REQ-016 Only one outbound request SHALL be outstanding; cmd_out_get_i SHALL toggle only on response arrival.
REQ-017 Simultaneous inbound response and outbound request issue in one cycle SHALL both take effect.

Reset
REQ-018 On reset: both FSMs at RX_SZ/IDLE; all outputs, tx_id, out-busy, toggle flags and data registers SHALL be 0; reset mid-frame SHALL discard the partial frame.

Configuration
REQ-019 With TBLINK_RPC_MSGPROC_IDCHK_EN defined, an inbound response whose ID differs from the outstanding tx_id SHALL be discarded with err pulsed and out-busy kept; without it, the ID SHALL be ignored.

Structure
REQ-020 State encodings, CMD_RSP constant (0) and frame-byte offsets SHALL live in package tblink_rpc_pkg.
REQ-021 TIPI frame serialiser SHALL be sub-module tblink_rpc_frame_tx.

Verification
REQ-022 Inbound 03 05 07 AA BB -> cmd_in=05, id=07, sz=2, params[15:0]=BBAA, put toggles once.
REQ-023 Client returns rsp_sz=1, rsp=0x5C -> TIPI sends 00 02 00 07 5C, then tipo_ready returns to 1.
REQ-024 cmd_out=09, sz=1, params=0x11 with tipi_ready toggling every cycle -> 00 02 09 00 11; next request uses ID 01.
REQ-025 Inbound response 02 00 00 EE -> cmd_out_rsp[7:0]=EE, rsp_sz=1, cmd_out_get_i toggles; second unsolicited response -> err pulse.
REQ-026 Request payload of 6 bytes with CMD_IN_PARAMS_SZ=4 -> bytes 4,5 dropped, sz=4 reported, no stall.
REQ-027 Reset asserted after tipo SZ/CMD bytes -> all outputs 0; next full frame decodes correctly.
